// File: rtl/mips_boot_loader.sv
// Boot sequencer for the single-cycle MIPS core: streams an image into IMEM/DMEM while holding the core in reset, then runs it.
// Optional build macro BOOT_CHECKSUM_EN adds an XOR checksum word and the CHECK state.
module mips_boot_loader #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] run_limit,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        cpu_reset,
  output logic        instr_write_enable,
  output logic [7:0]  instr_write_addr,
  output logic [31:0] instr_write_data,
  output logic        data_init_write_enable,
  output logic [7:0]  data_init_addr,
  output logic [31:0] data_init_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] cycle_count
);

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [3:0] {S_IDLE, S_HEADER, S_LOAD_I, S_LOAD_D, S_CHECK,
                            S_RELEASE, S_RUN, S_DONE, S_ERROR} state_t;
  localparam state_t S_POST = S_CHECK;
`else
  typedef enum logic [3:0] {S_IDLE, S_HEADER, S_LOAD_I, S_LOAD_D,
                            S_RELEASE, S_RUN, S_DONE, S_ERROR} state_t;
  localparam state_t S_POST = S_RELEASE;
`endif

  localparam logic [15:0] IMAX = 16'(IMEM_DEPTH);
  localparam logic [15:0] DMAX = 16'(DMEM_DEPTH);

  state_t      state_q, state_d;
  logic [15:0] ni_q, ni_d, nd_q, nd_d, idx_q, idx_d;
  logic [31:0] rl_q, rl_d, cyc_q, cyc_d;
  logic        done_q, done_d, err_q, err_d;
  logic        iwe_q, iwe_d, dwe_q, dwe_d;
  logic [7:0]  iaddr_q, iaddr_d, daddr_q, daddr_d;
  logic [31:0] idata_q, idata_d, ddata_q, ddata_d;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
`endif
  logic        accept;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ni_q <= '0; nd_q <= '0; idx_q <= '0; rl_q <= '0; cyc_q <= '0;
      done_q <= 1'b0; err_q <= 1'b0;
      iwe_q <= 1'b0; iaddr_q <= '0; idata_q <= '0;
      dwe_q <= 1'b0; daddr_q <= '0; ddata_q <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      ni_q <= ni_d; nd_q <= nd_d; idx_q <= idx_d; rl_q <= rl_d; cyc_q <= cyc_d;
      done_q <= done_d; err_q <= err_d;
      iwe_q <= iwe_d; iaddr_q <= iaddr_d; idata_q <= idata_d;
      dwe_q <= dwe_d; daddr_q <= daddr_d; ddata_q <= ddata_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ni_d = ni_q; nd_d = nd_q; idx_d = idx_q; rl_d = rl_q; cyc_d = cyc_q;
    done_d = done_q; err_d = err_q;
    iwe_d = 1'b0; iaddr_d = iaddr_q; idata_d = idata_q;
    dwe_d = 1'b0; daddr_d = daddr_q; ddata_d = ddata_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_HEADER;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cyc_d   = '0;
        end
      end
      S_HEADER: begin
        if (accept) begin
          ni_d  = in_data[31:16];
          nd_d  = in_data[15:0];
          rl_d  = run_limit;
          idx_d = '0;
`ifdef BOOT_CHECKSUM_EN
          csum_d = in_data;
`endif
          if (in_data[31:16] > IMAX || in_data[15:0] > DMAX) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else if (in_data[31:16] != '0) state_d = S_LOAD_I;
          else if (in_data[15:0] != '0)      state_d = S_LOAD_D;
          else                               state_d = S_POST;
        end
      end
      S_LOAD_I: begin
        if (accept) begin
          iwe_d   = 1'b1;
          iaddr_d = idx_q[7:0];
          idata_d = in_data;
`ifdef BOOT_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (idx_q == ni_q - 16'd1) begin
            idx_d   = '0;
            state_d = (nd_q != '0) ? S_LOAD_D : S_POST;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end
      S_LOAD_D: begin
        if (accept) begin
          dwe_d   = 1'b1;
          daddr_d = idx_q[7:0];
          ddata_d = in_data;
`ifdef BOOT_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (idx_q == nd_q - 16'd1) begin
            idx_d   = '0;
            state_d = S_POST;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          if (in_data == csum_q) state_d = S_RELEASE;
          else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      // Extra cycle so the last init write lands before the core leaves reset.
      S_RELEASE: state_d = S_RUN;
      S_RUN: begin
        cyc_d = cyc_q + 32'd1;
        if (rl_q != '0 && cyc_q + 32'd1 == rl_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_HEADER) || (state_q == S_LOAD_I) || (state_q == S_LOAD_D);
`ifdef BOOT_CHECKSUM_EN
    in_ready = in_ready || (state_q == S_CHECK);
`endif
    busy      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
    cpu_reset = (state_q != S_RUN);
  end

  assign instr_write_enable     = iwe_q;
  assign instr_write_addr       = iaddr_q;
  assign instr_write_data       = idata_q;
  assign data_init_write_enable = dwe_q;
  assign data_init_addr         = daddr_q;
  assign data_init_data         = ddata_q;
  assign done                   = done_q;
  assign error                  = err_q;
  assign cycle_count            = cyc_q;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Table-driven bench for mips_boot_loader with a write scoreboard on both init ports.
module tb_mips_boot_loader;
  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [31:0] run_limit, in_data;
  logic        in_ready, cpu_reset, instr_write_enable, data_init_write_enable;
  logic [7:0]  instr_write_addr, data_init_addr;
  logic [31:0] instr_write_data, data_init_data, cycle_count;
  logic        busy, done, error;

  always #5 clk = ~clk;

  mips_boot_loader dut (
    .clk(clk), .reset(reset), .start(start), .run_limit(run_limit),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .cpu_reset(cpu_reset),
    .instr_write_enable(instr_write_enable), .instr_write_addr(instr_write_addr),
    .instr_write_data(instr_write_data), .data_init_write_enable(data_init_write_enable),
    .data_init_addr(data_init_addr), .data_init_data(data_init_data),
    .busy(busy), .done(done), .error(error), .cycle_count(cycle_count)
  );

  int tests = 0;
  int fails = 0;
  logic [39:0] q_i[$];
  logic [39:0] q_d[$];

  typedef struct {
    logic [15:0] ni;
    logic [15:0] nd;
    logic [31:0] rl;
    bit          gap;
    bit          exp_err;
    logic [31:0] exp_cyc;
  } vec_t;
  vec_t vtab[7];

  task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  // Each write pulse must match the oldest outstanding expected write on that port.
  always @(negedge clk) begin
    if (instr_write_enable) begin
      if (q_i.size() == 0) begin
        tests++; fails++;
        $display("FAIL iwr_unexpected: got write addr %0d expected none", instr_write_addr);
      end else begin
        logic [39:0] e;
        e = q_i.pop_front();
        chkw("iwr_addr", 32'(instr_write_addr), 32'(e[39:32]));
        chkw("iwr_data", instr_write_data, e[31:0]);
      end
    end
    if (data_init_write_enable) begin
      if (q_d.size() == 0) begin
        tests++; fails++;
        $display("FAIL dwr_unexpected: got write addr %0d expected none", data_init_addr);
      end else begin
        logic [39:0] e;
        e = q_d.pop_front();
        chkw("dwr_addr", 32'(data_init_addr), 32'(e[39:32]));
        chkw("dwr_data", data_init_data, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_case(input vec_t v);
    logic [31:0] csum, w;
    int cnt;
    run_limit = v.rl;
    do_start();
    chk1("ready_after_start", in_ready, 1'b1);
    chk1("flags_cleared", done | error, 1'b0);
    chkw("count_cleared", cycle_count, 32'd0);
    csum = {v.ni, v.nd};
    send({v.ni, v.nd});
    if (v.exp_err) begin
      chk1("err_flag", error, 1'b1);
      chk1("err_ready", in_ready, 1'b0);
      chk1("err_busy", busy, 1'b0);
      repeat (3) tick();
      chk1("err_cpu_reset", cpu_reset, 1'b1);
      return;
    end
    for (int k = 0; k < int'(v.ni); k++) begin
      w = $urandom;
      q_i.push_back({8'(k), w});
      send(w);
      csum ^= w;
      if (v.gap && k != int'(v.ni) - 1) repeat (2) tick();
    end
    for (int k = 0; k < int'(v.nd); k++) begin
      w = $urandom;
      q_d.push_back({8'(k), w});
      send(w);
      csum ^= w;
    end
`ifdef BOOT_CHECKSUM_EN
    send(csum);
`endif
    chk1("release_cpu_reset", cpu_reset, 1'b1);
    tick();
    chk1("cpu_reset_fall", cpu_reset, 1'b0);
    cnt = 0;
    while (cpu_reset == 1'b0 && cnt < 1000) begin
      cnt++;
      tick();
    end
    chkw("run_cycles", cnt, v.exp_cyc);
    chk1("done_flag", done, 1'b1);
    chkw("cycle_count", cycle_count, v.exp_cyc);
    chkw("writes_drained", q_i.size() + q_d.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vtab[0] = '{16'd3,   16'd2,   32'd10, 1'b0, 1'b0, 32'd10};
    vtab[1] = '{16'd0,   16'd0,   32'd3,  1'b0, 1'b0, 32'd3};
    vtab[2] = '{16'h101, 16'd0,   32'd5,  1'b0, 1'b1, 32'd0};
    vtab[3] = '{16'd4,   16'd0,   32'd5,  1'b1, 1'b0, 32'd5};
    vtab[4] = '{16'd0,   16'd3,   32'd1,  1'b0, 1'b0, 32'd1};
    vtab[5] = '{16'd256, 16'd1,   32'd2,  1'b0, 1'b0, 32'd2};
    vtab[6] = '{16'd0,   16'd257, 32'd4,  1'b0, 1'b1, 32'd0};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; run_limit = '0;
    repeat (2) tick();
    reset = 1'b0;
    chk1("rst_cpu_reset", cpu_reset, 1'b1);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_error", error, 1'b0);
    chkw("rst_cycle_count", cycle_count, 32'd0);
    chk1("rst_iwe", instr_write_enable | data_init_write_enable, 1'b0);
    chkw("rst_addrs", {16'd0, instr_write_addr, data_init_addr}, 32'd0);
    chkw("rst_idata", instr_write_data, 32'd0);
    chkw("rst_ddata", data_init_data, 32'd0);

    for (int i = 0; i < 7; i++) run_case(vtab[i]);

    // Reset in the middle of a 5-word instruction load, then reload from address 0.
    run_limit = 32'd4;
    do_start();
    send({16'd5, 16'd0});
    for (int k = 0; k < 2; k++) begin
      logic [31:0] w;
      w = $urandom;
      q_i.push_back({8'(k), w});
      send(w);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("midrst_ready", in_ready, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_cpu_reset", cpu_reset, 1'b1);
    chk1("midrst_iwe", instr_write_enable, 1'b0);
    chkw("midrst_iaddr", 32'(instr_write_addr), 32'd0);
    chkw("midrst_drained", q_i.size(), 32'd0);
    v = '{16'd2, 16'd1, 32'd3, 1'b0, 1'b0, 32'd3};
    run_case(v);

    // Unlimited run: counter keeps going, start is ignored while running.
    run_limit = 32'd0;
    do_start();
    send({16'd1, 16'd0});
    q_i.push_back({8'd0, 32'hCAFE_F00D});
    send(32'hCAFE_F00D);
`ifdef BOOT_CHECKSUM_EN
    send(32'hCAFE_F00D ^ 32'h0001_0000);
`endif
    tick();
    chk1("unl_cpu_reset_fall", cpu_reset, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    chkw("unl_cycle_count", cycle_count, 32'd20);
    chk1("unl_cpu_reset", cpu_reset, 1'b0);
    chk1("unl_busy", busy, 1'b1);
    chk1("unl_done", done, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("unl_reset_cpu", cpu_reset, 1'b1);
    chkw("unl_reset_count", cycle_count, 32'd0);

`ifdef BOOT_CHECKSUM_EN
    run_limit = 32'd2;
    do_start();
    send(32'h0001_0000);
    q_i.push_back({8'd0, 32'h1234_5678});
    send(32'h1234_5678);
    send(32'h1235_5679);
    chk1("csum_bad_err", error, 1'b1);
    chk1("csum_bad_ready", in_ready, 1'b0);
    repeat (3) tick();
    chk1("csum_bad_cpu_reset", cpu_reset, 1'b1);
    do_start();
    send(32'h0001_0000);
    q_i.push_back({8'd0, 32'h1234_5678});
    send(32'h1234_5678);
    send(32'h1235_5678);
    tick();
    chk1("csum_good_run", cpu_reset, 1'b0);
    chk1("csum_good_noerr", error, 1'b0);
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
